// File: rtl/reset_seq.sv
// Reset sequencer: holds a bank of active-high resets until PLL lock has been
// stable for HOLD_CYCLES, then releases them in index order STAGGER cycles apart.
module reset_seq #(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               locked,
  input  logic               sw_rst,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = $clog2(NUM_OUT) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lock_meta;
  logic          locked_s;

  // locked comes straight from the PLL, so it crosses into clk here
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else if (!locked_s && state != WAIT_LOCK) begin
      // lock loss outranks a coincident software request
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else if (sw_rst && state != WAIT_LOCK) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            idx        <= IW'(1);
            if (NUM_OUT == 1) begin
              state <= RUN;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == STAG_LAST) begin
            for (int i = 1; i < NUM_OUT; i++)
              if (idx == IW'(i)) rst_out[i] <= 1'b0;
            cnt <= '0;
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= RUN;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN:     ;
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: default instance plus a NUM_OUT=1/HOLD=1 corner,
// both checked against a release-time model driven by the same stimulus.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       locked = 1'b0;
  logic       sw_rst = 1'b0;
  logic [2:0] rst_a;
  logic       rdy_a, bsy_a;
  logic [0:0] rst_b;
  logic       rdy_b, bsy_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_seq #(.NUM_OUT(3), .HOLD_CYCLES(16), .STAGGER(8)) dut_a (
    .clk(clk), .arst_n(arst_n), .locked(locked), .sw_rst(sw_rst),
    .rst_out(rst_a), .ready(rdy_a), .busy(bsy_a));

  reset_seq #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER(8)) dut_b (
    .clk(clk), .arst_n(arst_n), .locked(locked), .sw_rst(sw_rst),
    .rst_out(rst_b), .ready(rdy_b), .busy(bsy_b));

  typedef struct {
    logic [2:0] r_a;
    logic       y_a;
    logic       b_a;
    logic [0:0] r_b;
    logic       y_b;
    logic       b_b;
  } exp_t;

  exp_t sb[$];

  // Model: the sequence starts at edge e; output i is released once
  // hold + i*stagger edges have passed since then.
  function automatic logic [7:0] exp_rst(int nout, int h, int s, bit seq, int t);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < nout; i++) r[i] = !seq || (t < h + i * s);
    return r;
  endfunction

  function automatic logic exp_rdy(int nout, int h, int s, bit seq, int t);
    return seq && (t >= h + (nout - 1) * s);
  endfunction

  bit seq;
  int e_edge;
  int n_edge;
  bit lk1, lk2;

  function automatic exp_t mk_exp(bit sq, int t);
    exp_t x;
    logic [7:0] ra, rb;
    ra    = exp_rst(3, 16, 8, sq, t);
    rb    = exp_rst(1, 1, 8, sq, t);
    x.r_a = ra[2:0];
    x.y_a = exp_rdy(3, 16, 8, sq, t);
    x.b_a = !x.y_a;
    x.r_b = rb[0:0];
    x.y_b = exp_rdy(1, 1, 8, sq, t);
    x.b_b = !x.y_b;
    return x;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      seq    = 1'b0;
      lk1    = 1'b0;
      lk2    = 1'b0;
      e_edge = 0;
      sb.delete();
      sb.push_back(mk_exp(1'b0, 0));
    end else begin
      bit ls;
      n_edge++;
      ls  = lk2;              // lock as seen two edges ago
      lk2 = lk1;
      lk1 = locked;
      if (!seq) begin
        if (ls) begin seq = 1'b1; e_edge = n_edge; end
      end else if (!ls) begin
        seq = 1'b0;
      end else if (sw_rst) begin
        e_edge = n_edge;
      end
      sb.push_back(mk_exp(seq, n_edge - e_edge));
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("rst_out_a", {5'b0, rst_a}, {5'b0, x.r_a});
      chk("ready_a",   {7'b0, rdy_a}, {7'b0, x.y_a});
      chk("busy_a",    {7'b0, bsy_a}, {7'b0, x.b_a});
      chk("rst_out_b", {7'b0, rst_b}, {7'b0, x.r_b});
      chk("ready_b",   {7'b0, rdy_b}, {7'b0, x.y_b});
      chk("busy_b",    {7'b0, bsy_b}, {7'b0, x.b_b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic pulse_sw();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
  endtask

  task automatic async_rst(int hold);
    #1 arst_n = 1'b0;          // lands between edges
    ticks(hold);
    arst_n = 1'b1;
  endtask

  initial begin
    ticks(3);
    arst_n = 1'b1;
    ticks(20);                 // no lock: held in reset
    locked = 1'b1;
    ticks(45);                 // full sequence into RUN
    pulse_sw();
    ticks(40);                 // software re-sequence from RUN
    pulse_sw();
    ticks(19);                 // rst_out[0] released, still in RELEASE
    locked = 1'b0;
    ticks(5);
    locked = 1'b1;
    ticks(45);
    pulse_sw();
    ticks(9);                  // mid-hold
    pulse_sw();
    ticks(40);
    locked = 1'b0;
    ticks(2);
    locked = 1'b1;             // sw and lock loss land on the same edge
    pulse_sw();
    locked = 1'b1;
    ticks(45);
    pulse_sw();
    ticks(22);
    async_rst(2);
    ticks(45);

    for (int c = 0; c < 3000; c++) begin
      if (locked) begin
        if ($urandom_range(0, 199) == 0) locked = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        locked = 1'b1;
      end
      sw_rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 599) == 0) async_rst($urandom_range(1, 3));
      else tick();
    end
    sw_rst = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
